// File: rtl/stack_lifo_pkg.sv
// Shared definitions for the parametrised LIFO stack: op encodings and count-width helper.
// Used by stack_lifo_param_if, stack_lifo_mem and stack_lifo_param.
package stack_lifo_pkg;

    // Op code is the concatenation {push, pop}
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    // Width needed to hold every occupancy value 0..depth inclusive
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Address width for a depth-entry array (at least one bit)
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stack_lifo_param_if.sv
// Handshake/data bundle between a stack client (master) and stack_lifo_param (slave).
interface stack_lifo_param_if
    import stack_lifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) ();

    localparam int CNT_W = clog2_cnt(DEPTH);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic [WIDTH-1:0] top;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             ovf_err;
    logic             udf_err;

    modport master (
        output push, pop, data_in,
        input  data_out, out_valid, top, count, empty, full, ovf_err, udf_err
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, out_valid, top, count, empty, full, ovf_err, udf_err
    );

endinterface

// File: rtl/stack_lifo_mem.sv
// WIDTH x DEPTH storage array for the LIFO: one synchronous write port, one asynchronous read port.
module stack_lifo_mem
    import stack_lifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-power-of-two depths leave unused address codes; read them as zero
    always_comb begin
        rdata_o = '0;
        if (int'(raddr_i) < DEPTH) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/stack_lifo_param.sv
// Parametrised LIFO stack with occupancy count, top peek, registered pop data and replace-top.
// Optional sticky overflow/underflow flags when STACK_LIFO_ERR_EN is defined.
module stack_lifo_param
    import stack_lifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst,
    stack_lifo_param_if.slave  bus
);

    localparam int CNT_W = clog2_cnt(DEPTH);
    localparam int AW    = addr_w(DEPTH);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;

    logic             empty_c;
    logic             full_c;
    logic [1:0]       op_c;
    logic [CNT_W-1:0] top_idx_c;
    logic [AW-1:0]    top_addr_c;
    logic [AW-1:0]    push_addr_c;
    logic [WIDTH-1:0] rdata_c;

    logic             we_c;
    logic [AW-1:0]    waddr_c;
    logic             ovf_ev_c;
    logic             udf_ev_c;

    assign empty_c     = (count_q == CNT_ZERO);
    assign full_c      = (count_q == CNT_FULL);
    assign op_c        = {bus.push, bus.pop};
    assign top_idx_c   = count_q - CNT_ONE;
    assign top_addr_c  = top_idx_c[AW-1:0];
    assign push_addr_c = count_q[AW-1:0];

    stack_lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (we_c & ~rst),
        .waddr_i (waddr_c),
        .wdata_i (bus.data_in),
        .raddr_i (top_addr_c),
        .rdata_o (rdata_c)
    );

    // Next-state decode of the {push,pop} request against current occupancy
    always_comb begin
        count_d     = count_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        we_c        = 1'b0;
        waddr_c     = push_addr_c;
        ovf_ev_c    = 1'b0;
        udf_ev_c    = 1'b0;
        case (op_c)
            OP_PUSH: begin
                if (!full_c) begin
                    we_c    = 1'b1;
                    count_d = count_q + CNT_ONE;
                end else begin
                    ovf_ev_c = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty_c) begin
                    data_out_d  = rdata_c;
                    out_valid_d = 1'b1;
                    count_d     = top_idx_c;
                end else begin
                    udf_ev_c = 1'b1;
                end
            end
            OP_REPL: begin
                we_c = 1'b1;
                if (!empty_c) begin
                    // Old top is read before the write lands, so data_out gets the replaced word
                    data_out_d  = rdata_c;
                    out_valid_d = 1'b1;
                    waddr_c     = top_addr_c;
                end else begin
                    count_d  = CNT_ONE;
                    udf_ev_c = 1'b1;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef STACK_LIFO_ERR_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ovf_ev_c) begin
                ovf_q <= 1'b1;
            end
            if (udf_ev_c) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.ovf_err = ovf_q;
    assign bus.udf_err = udf_q;
`else
    logic unused_ev;
    assign unused_ev   = ovf_ev_c | udf_ev_c;
    assign bus.ovf_err = 1'b0;
    assign bus.udf_err = 1'b0;
`endif

    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.top       = empty_c ? '0 : rdata_c;
    assign bus.count     = count_q;
    assign bus.empty     = empty_c;
    assign bus.full      = full_c;

endmodule

// File: tb/tb_stack_lifo_param.sv
// Directed table-driven bench for stack_lifo_param (WIDTH=8, DEPTH=4); error-flag
// expectations follow whether STACK_LIFO_ERR_EN is defined for the build.
module tb_stack_lifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

`ifdef STACK_LIFO_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk;
    logic rst;

    stack_lifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stack_lifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             push;
        logic             pop;
        logic [WIDTH-1:0] din;
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] top;
        logic             ov;
        logic [WIDTH-1:0] dout;
        logic             ovf;
        logic             udf;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   passed;

    task automatic add(input logic r, input logic pu, input logic po, input logic [7:0] d,
                       input logic [2:0] c, input logic [7:0] t, input logic v,
                       input logic [7:0] o, input logic of, input logic uf);
        vec_t x;
        x.rst = r; x.push = pu; x.pop = po; x.din = d;
        x.cnt = c; x.top = t; x.ov = v; x.dout = o; x.ovf = of; x.udf = uf;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic chk_all(input int idx, input logic [2:0] c, input logic [7:0] t,
                           input logic v, input logic [7:0] o, input logic of,
                           input logic uf);
        chk("count", idx, 32'(bus.count), 32'(c));
        chk("top", idx, 32'(bus.top), 32'(t));
        chk("out_valid", idx, 32'(bus.out_valid), 32'(v));
        chk("data_out", idx, 32'(bus.data_out), 32'(o));
        chk("empty", idx, 32'(bus.empty), 32'(c == 3'd0));
        chk("full", idx, 32'(bus.full), 32'(c == 3'd4));
        chk("ovf_err", idx, 32'(bus.ovf_err), 32'(of & ERR_ON));
        chk("udf_err", idx, 32'(bus.udf_err), 32'(uf & ERR_ON));
    endtask

    task automatic step(input logic r, input logic pu, input logic po, input logic [7:0] d);
        rst         = r;
        bus.push    = pu;
        bus.pop     = po;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] words [4];
        total       = 0;
        passed      = 0;
        rst         = 1'b1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;

        //   rst pu po din    cnt top    ov dout   ovf udf
        add(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);   // reset
        add(0, 1, 0, 8'hA1, 1, 8'hA1, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'hB2, 2, 8'hB2, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'hC3, 3, 8'hC3, 0, 8'h00, 0, 0);
        add(0, 0, 1, 8'h00, 2, 8'hB2, 1, 8'hC3, 0, 0);
        add(0, 0, 1, 8'h00, 1, 8'hA1, 1, 8'hB2, 0, 0);
        add(0, 0, 1, 8'h00, 0, 8'h00, 1, 8'hA1, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'hA1, 0, 0);   // strobe drops, data held
        add(0, 0, 1, 8'h00, 0, 8'h00, 0, 8'hA1, 0, 1);   // pop on empty
        add(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'hA1, 0, 1);   // sticky
        add(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h10, 1, 8'h10, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h11, 2, 8'h11, 0, 8'h00, 0, 0);
        add(0, 1, 1, 8'h22, 2, 8'h22, 1, 8'h11, 0, 0);   // replace-top
        add(0, 1, 0, 8'h33, 3, 8'h33, 0, 8'h11, 0, 0);
        add(0, 1, 0, 8'h44, 4, 8'h44, 0, 8'h11, 0, 0);   // full
        add(0, 1, 1, 8'h66, 4, 8'h66, 1, 8'h44, 0, 0);   // replace at full, no overflow
        add(0, 1, 0, 8'h55, 4, 8'h66, 0, 8'h44, 1, 0);   // dropped push
        add(0, 0, 1, 8'h00, 3, 8'h33, 1, 8'h66, 1, 0);
        add(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);
        add(0, 1, 1, 8'h5A, 1, 8'h5A, 0, 8'h00, 0, 1);   // push+pop on empty
        add(0, 0, 1, 8'h00, 0, 8'h00, 1, 8'h5A, 0, 1);
        add(0, 1, 0, 8'h01, 1, 8'h01, 0, 8'h5A, 0, 1);
        add(0, 1, 0, 8'h02, 2, 8'h02, 0, 8'h5A, 0, 1);
        add(0, 1, 0, 8'h03, 3, 8'h03, 0, 8'h5A, 0, 1);
        add(1, 1, 0, 8'h04, 0, 8'h00, 0, 8'h00, 0, 0);   // reset beats push
        add(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].din);
            chk_all(i, vecs[i].cnt, vecs[i].top, vecs[i].ov, vecs[i].dout,
                    vecs[i].ovf, vecs[i].udf);
        end

        // Fill with distinct words, then drain and confirm reverse order
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = 8'(8'h37 * (i + 1) + 8'h05);
            step(1'b0, 1'b1, 1'b0, words[i]);
            chk("fill_count", 100 + i, 32'(bus.count), 32'(i + 1));
            chk("fill_top", 100 + i, 32'(bus.top), 32'(words[i]));
        end
        chk("fill_full", 104, 32'(bus.full), 32'd1);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain_data", 200 + i, 32'(bus.data_out), 32'(words[i]));
            chk("drain_valid", 200 + i, 32'(bus.out_valid), 32'd1);
            chk("drain_count", 200 + i, 32'(bus.count), 32'(i));
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("drain_hold", 300, 32'(bus.data_out), 32'(words[0]));
        chk("drain_strobe", 300, 32'(bus.out_valid), 32'd0);
        chk("drain_empty", 300, 32'(bus.empty), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
